// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handshake
// and branch redirect. master = fetch unit, slave = memory/decode side.
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_rsp_valid;
    logic [31:0]         imem_rsp_data;
    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] inst_pc;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;

    modport master (
        output imem_req_valid,
        output imem_addr,
        output inst_valid,
        output inst,
        output inst_pc,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output inst_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues sequential word fetches,
// buffers responses in an in-order FIFO and hands them to decode.
// Ports: clk, rst (sync, active-high), bus (instr_fetch_unit_if.master).
module instr_fetch_unit #(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] rsp_pc;
    logic [CW-1:0]       count;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       drop;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [31:0]         word_q [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] pc_q   [FIFO_DEPTH];

    logic                redirect;
    logic                rsp;
    logic                pop;
    logic                push;
    logic                fire;
    logic [CW:0]         credit;
    logic [PC_WIDTH-1:0] target;

    assign redirect = bus.redirect_valid;
    assign rsp      = bus.imem_rsp_valid;
    assign target   = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};

    assign bus.inst_valid = (count != '0) && !redirect;
    assign pop            = bus.inst_valid && bus.inst_ready;

    // Every in-flight request owns a FIFO slot, so a response never
    // finds the buffer full.
    assign credit = {1'b0, count} + {1'b0, outstanding} - (CW+1)'(pop);

    assign bus.imem_req_valid = !rst && !redirect && (credit < DEPTH_W);
    assign fire               = bus.imem_req_valid && bus.imem_req_ready;
    assign push               = rsp && (drop == '0) && !redirect;

    assign bus.imem_addr = fetch_pc;
    assign bus.inst      = word_q[rd_ptr];
    assign bus.inst_pc   = pc_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (redirect) begin
            // Everything still in flight belongs to the old path.
            fetch_pc    <= target;
            rsp_pc      <= target;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding - CW'(rsp);
            drop        <= outstanding - CW'(rsp);
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + PC_WIDTH'(4);
            end
            outstanding <= outstanding + CW'(fire) - CW'(rsp);
            if (rsp && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            // Responses return in request order, so the pc of the next
            // kept response simply steps by one word per push.
            if (push) begin
                word_q[wr_ptr] <= bus.imem_rsp_data;
                pc_q[wr_ptr]   <= rsp_pc;
                wr_ptr         <= wr_ptr + AW'(1);
                rsp_pc         <= rsp_pc + PC_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: latency-programmable memory model,
// in-order decode scoreboard and cycle-exact checks of reset/redirect.
module tb_instr_fetch_unit;
    localparam int          PW     = 32;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_WIDTH(PW)) bus ();

    instr_fetch_unit #(
        .PC_WIDTH  (PW),
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        q[$];
    int          cyc    = 0;
    int          lat    = 1;
    int          n_xfer = 0;
    logic [31:0] exp_pc = RST_PC;

    // Memory model plus decode scoreboard: sample at negedge, drive
    // responses just after the rising edge.
    initial begin : model
        logic        f;
        logic        r;
        logic        rv;
        logic [31:0] a;
        logic [31:0] rp;
        req_t        e;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            f  = bus.imem_req_valid && bus.imem_req_ready;
            a  = bus.imem_addr;
            r  = rst;
            rv = bus.redirect_valid;
            rp = bus.redirect_pc;
            if (rv) check("valid_on_redirect", 64'(bus.inst_valid), 64'd0);
            if (bus.inst_valid && bus.inst_ready) begin
                check("inst_pc", 64'(bus.inst_pc), 64'(exp_pc));
                check("inst", 64'(bus.inst), 64'(word_of(exp_pc)));
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            if (r) exp_pc = RST_PC;
            else if (rv) exp_pc = rp & ~32'd3;
            if (f) begin
                check("addr_align", 64'(a[1:0]), 64'd0);
                e.addr = a;
                e.due  = cyc + lat;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (r) q.delete();
            bus.imem_rsp_valid = 1'b0;
            if (q.size() > 0 && q[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = word_of(q[0].addr);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int x0;

    initial begin
        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset state
        adv(1);
        @(negedge clk);
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_inst", 64'(bus.inst), 64'd0);
        check("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
        check("rst_outstanding", 64'(dut.outstanding), 64'd0);

        // Streaming from RESET_PC, wrapping through zero
        adv(1);
        rst = 1'b0;
        @(negedge clk);
        check("r0_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("r0_addr", 64'(bus.imem_addr), 64'hFFFF_FFF8);
        check("r0_inst_valid", 64'(bus.inst_valid), 64'd0);
        adv(1);
        @(negedge clk);
        check("r1_addr", 64'(bus.imem_addr), 64'hFFFF_FFFC);
        check("r1_inst_valid", 64'(bus.inst_valid), 64'd0);
        adv(1);
        x0 = n_xfer;
        @(negedge clk);
        check("r2_inst_valid", 64'(bus.inst_valid), 64'd1);
        check("r2_inst_pc", 64'(bus.inst_pc), 64'hFFFF_FFF8);
        check("r2_addr_wrap", 64'(bus.imem_addr), 64'd0);
        adv(10);
        check("stream_rate", 64'(n_xfer - x0), 64'd10);

        // Backpressure fills exactly FIFO_DEPTH entries
        bus.inst_ready = 1'b0;
        adv(20);
        @(negedge clk);
        check("bp_count", 64'(dut.count), 64'd4);
        check("bp_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("bp_outstanding", 64'(dut.outstanding), 64'd0);
        check("bp_inst_valid", 64'(bus.inst_valid), 64'd1);
        adv(1);
        bus.inst_ready = 1'b1;
        x0 = n_xfer;
        adv(12);
        check("drain_rate", 64'(n_xfer - x0), 64'd12);

        // Redirect with two fetches in flight, latency 3
        bus.imem_req_ready = 1'b0;
        lat = 3;
        adv(8);
        @(negedge clk);
        check("idle_outstanding", 64'(dut.outstanding), 64'd0);
        check("idle_count", 64'(dut.count), 64'd0);
        adv(1);
        bus.imem_req_ready = 1'b1;
        adv(2);
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0106;
        @(negedge clk);
        check("rd1_outstanding", 64'(dut.outstanding), 64'd2);
        check("rd1_req_valid", 64'(bus.imem_req_valid), 64'd0);
        adv(1);
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        check("rd1_addr", 64'(bus.imem_addr), 64'h104);
        check("rd1_drop", 64'(dut.drop), 64'd2);
        check("rd1_req_after", 64'(bus.imem_req_valid), 64'd1);
        adv(2);
        @(negedge clk);
        check("rd1_drop_done", 64'(dut.drop), 64'd0);
        check("rd1_no_stale", 64'(bus.inst_valid), 64'd0);
        adv(2);
        @(negedge clk);
        check("rd1_tgt_valid", 64'(bus.inst_valid), 64'd1);
        check("rd1_tgt_pc", 64'(bus.inst_pc), 64'h104);

        // Redirect coincident with a response and a would-be pop
        adv(1);
        bus.imem_req_ready = 1'b0;
        adv(8);
        lat = 2;
        bus.imem_req_ready = 1'b1;
        adv(8);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        check("rd2_count", 64'(dut.count), 64'd1);
        check("rd2_outstanding", 64'(dut.outstanding), 64'd2);
        check("rd2_rsp", 64'(bus.imem_rsp_valid), 64'd1);
        check("rd2_inst_valid", 64'(bus.inst_valid), 64'd0);
        adv(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("rd2_drop", 64'(dut.drop), 64'd1);
        check("rd2_outstanding_after", 64'(dut.outstanding), 64'd1);
        check("rd2_count_after", 64'(dut.count), 64'd0);
        check("rd2_addr", 64'(bus.imem_addr), 64'h200);
        adv(1);
        @(negedge clk);
        check("rd2_drop_done", 64'(dut.drop), 64'd0);
        adv(2);
        @(negedge clk);
        check("rd2_tgt_valid", 64'(bus.inst_valid), 64'd1);
        check("rd2_tgt_pc", 64'(bus.inst_pc), 64'h200);

        // Reset with a full FIFO
        adv(1);
        lat = 1;
        bus.inst_ready = 1'b0;
        adv(12);
        @(negedge clk);
        check("full_count", 64'(dut.count), 64'd4);
        adv(1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        adv(1);
        rst = 1'b0;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 64'(bus.inst_valid), 64'd0);
        check("post_rst_count", 64'(dut.count), 64'd0);
        check("post_rst_outstanding", 64'(dut.outstanding), 64'd0);
        check("post_rst_drop", 64'(dut.drop), 64'd0);
        check("post_rst_addr", 64'(bus.imem_addr), 64'(RST_PC));
        check("post_rst_req_valid", 64'(bus.imem_req_valid), 64'd1);
        adv(2);
        @(negedge clk);
        check("post_rst_first_pc", 64'(bus.inst_pc), 64'(RST_PC));
        check("post_rst_first_valid", 64'(bus.inst_valid), 64'd1);
        adv(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
